// File: rtl/iob_eth_pkg.sv
// Shared definitions for the iob_eth memory arbiter: FSM encoding, requester
// indices and the default watchdog width.
package iob_eth_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam logic ARB_REQ_DMA = 1'b0;
   localparam logic ARB_REQ_CPU = 1'b1;

   localparam int ARB_TIMEOUT_W = 10;

endpackage

// File: rtl/iob_eth_arb_rr2.sv
// Two-way round-robin picker: combinational pick from the request vector plus
// the last-winner register that breaks ties in favour of the other requester.
module iob_eth_arb_rr2
   import iob_eth_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic       pick
);

   logic last_q;

   // NOTE: a default ahead of the branches keeps always_comb free of latches.
   always_comb begin
      pick = ARB_REQ_DMA;
      if (req == 2'b11) begin
         pick = ~last_q;
      end else if (req[1]) begin
         pick = ARB_REQ_CPU;
      end
   end

   // Resets to the CPU side so the DMA master wins the first tie.
   // NOTE: sequential state uses non-blocking assignment only.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= ARB_REQ_CPU;
      end else if (update) begin
         last_q <= pick;
      end
   end

endmodule

// File: rtl/iob_eth_mem_arbiter.sv
// Round-robin arbiter for the shared IOb memory port (r0 = Ethernet DMA, r1 = second master).
// Optional watchdog enabled by defining IOB_ETH_ARB_TIMEOUT_EN.
module iob_eth_mem_arbiter
   import iob_eth_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = ARB_TIMEOUT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                r0_valid,
   input  logic [ADDR_W-1:0]   r0_addr,
   input  logic [DATA_W-1:0]   r0_wdata,
   input  logic [DATA_W/8-1:0] r0_wstrb,
   output logic [DATA_W-1:0]   r0_rdata,
   output logic                r0_ready,
   input  logic                r1_valid,
   input  logic [ADDR_W-1:0]   r1_addr,
   input  logic [DATA_W-1:0]   r1_wdata,
   input  logic [DATA_W/8-1:0] r1_wstrb,
   output logic [DATA_W-1:0]   r1_rdata,
   output logic                r1_ready,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_ready,
   output logic                busy_o,
   output logic                grant_o,
   output logic                timeout_o
);

   arb_state_t state, state_n;
   logic       pick;
   logic       start;
   logic       wd_expire;
   logic       txn_done;

   assign start    = (state == ARB_IDLE) && (r0_valid || r1_valid);
   assign txn_done = m_ready || wd_expire;
   assign busy_o   = (state == ARB_BUSY);

   iob_eth_arb_rr2 u_rr2 (
      .clk    (clk),
      .rst    (rst),
      .req    ({r1_valid, r0_valid}),
      .update (start),
      .pick   (pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ARB_IDLE;
         grant_o <= ARB_REQ_DMA;
      end else begin
         state <= state_n;
         if (start) begin
            grant_o <= pick;
         end
      end
   end

   // The grant is held even if the requester drops valid; only m_ready or the
   // watchdog ends a transaction, so the owner always sees its ready pulse.
   always_comb begin
      state_n  = state;
      m_valid  = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      m_wstrb  = '0;
      r0_ready = 1'b0;
      r0_rdata = '0;
      r1_ready = 1'b0;
      r1_rdata = '0;
      case (state)
         ARB_IDLE: begin
            if (start) begin
               state_n = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (grant_o == ARB_REQ_DMA) begin
               m_valid  = r0_valid;
               m_addr   = r0_addr;
               m_wdata  = r0_wdata;
               m_wstrb  = r0_wstrb;
               r0_ready = txn_done;
               r0_rdata = m_ready ? m_rdata : '0;
            end else begin
               m_valid  = r1_valid;
               m_addr   = r1_addr;
               m_wdata  = r1_wdata;
               m_wstrb  = r1_wstrb;
               r1_ready = txn_done;
               r1_rdata = m_ready ? m_rdata : '0;
            end
            if (txn_done) begin
               state_n = ARB_IDLE;
            end
         end
         default: state_n = ARB_IDLE;
      endcase
   end

`ifdef IOB_ETH_ARB_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wd_cnt;
   logic                 timeout_q;

   // A late m_ready on the terminal count wins: expiry requires !m_ready.
   assign wd_expire = (state == ARB_BUSY) && !m_ready && (wd_cnt == '1);
   assign timeout_o = timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == ARB_IDLE) begin
            wd_cnt <= '0;
         end else if (!m_ready) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (wd_expire) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   logic [TIMEOUT_W-1:0] unused_timeout_w;

   assign unused_timeout_w = '0;
   assign wd_expire        = 1'b0;
   assign timeout_o        = 1'b0;
`endif

endmodule
